// File: rtl/hue_sequencer.sv
// RGB hue-wheel sequencer: six-phase ramp of r/g/b duty values for downstream PWM blocks.
// Optional HUE_SEQ_SYNC_EN: duties come from shadow registers loaded on period_start.
module hue_sequencer #(
  parameter int PWM_INTERVAL    = 1200,
  parameter int STEPS_PER_PHASE = 100,
  parameter int STEP_CYCLES     = 20000
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            enable,
`ifdef HUE_SEQ_SYNC_EN
  input  logic                            period_start,
`endif
  output logic [$clog2(PWM_INTERVAL)-1:0] r_duty,
  output logic [$clog2(PWM_INTERVAL)-1:0] g_duty,
  output logic [$clog2(PWM_INTERVAL)-1:0] b_duty,
  output logic [2:0]                      phase,
  output logic                            phase_start
);
  localparam int W         = $clog2(PWM_INTERVAL);
  localparam int STEP_SIZE = PWM_INTERVAL / STEPS_PER_PHASE;
  localparam int IW        = (STEPS_PER_PHASE > 1) ? $clog2(STEPS_PER_PHASE) : 1;
  localparam int CW        = (STEP_CYCLES > 1) ? $clog2(STEP_CYCLES) : 1;
  localparam int SW        = $clog2(STEP_SIZE + 1);
  // Ramp arithmetic is wide enough for both the full product and PWM_INTERVAL itself.
  localparam int RW        = (IW + SW > W) ? IW + SW : W;

  localparam logic [CW-1:0] CYC_LAST = CW'(STEP_CYCLES - 1);
  localparam logic [IW-1:0] INC_LAST = IW'(STEPS_PER_PHASE - 1);
  localparam logic [RW-1:0] MAX_R    = RW'(PWM_INTERVAL);
  localparam logic [RW-1:0] STEP_R   = RW'(STEP_SIZE);

  if ((PWM_INTERVAL & (PWM_INTERVAL - 1)) == 0) begin : g_err_pow2
    $error("hue_sequencer: PWM_INTERVAL must not be a power of two");
  end
  if (STEPS_PER_PHASE < 1 || (PWM_INTERVAL % STEPS_PER_PHASE) != 0) begin : g_err_steps
    $error("hue_sequencer: STEPS_PER_PHASE must divide PWM_INTERVAL");
  end
  if (STEP_CYCLES < 1) begin : g_err_cycles
    $error("hue_sequencer: STEP_CYCLES must be >= 1");
  end

  logic [CW-1:0] cyc_q, cyc_d;
  logic [IW-1:0] inc_q, inc_d;
  logic [2:0]    phase_q, phase_d;
  logic          phase_start_q, phase_start_d;

  always_comb begin
    cyc_d         = cyc_q;
    inc_d         = inc_q;
    phase_d       = phase_q;
    phase_start_d = 1'b0;
    if (enable) begin
      if (cyc_q == CYC_LAST) begin
        cyc_d = '0;
        if (inc_q == INC_LAST) begin
          inc_d         = '0;
          phase_d       = (phase_q == 3'd5) ? 3'd0 : phase_q + 3'd1;
          phase_start_d = 1'b1;
        end else begin
          inc_d = inc_q + IW'(1);
        end
      end else begin
        cyc_d = cyc_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cyc_q         <= '0;
      inc_q         <= '0;
      phase_q       <= 3'd0;
      phase_start_q <= 1'b0;
    end else begin
      cyc_q         <= cyc_d;
      inc_q         <= inc_d;
      phase_q       <= phase_d;
      phase_start_q <= phase_start_d;
    end
  end

  logic [RW-1:0] ramp_up, ramp_dn;
  logic [RW-1:0] dec_r, dec_g, dec_b;

  assign ramp_up = RW'(inc_q) * STEP_R;
  assign ramp_dn = MAX_R - ramp_up;

  always_comb begin
    dec_r = MAX_R;
    dec_g = '0;
    dec_b = '0;
    case (phase_q)
      3'd0: begin dec_r = MAX_R;   dec_g = ramp_up; dec_b = '0;      end
      3'd1: begin dec_r = ramp_dn; dec_g = MAX_R;   dec_b = '0;      end
      3'd2: begin dec_r = '0;      dec_g = MAX_R;   dec_b = ramp_up; end
      3'd3: begin dec_r = '0;      dec_g = ramp_dn; dec_b = MAX_R;   end
      3'd4: begin dec_r = ramp_up; dec_g = '0;      dec_b = MAX_R;   end
      3'd5: begin dec_r = MAX_R;   dec_g = '0;      dec_b = ramp_dn; end
      default: ;
    endcase
  end

`ifdef HUE_SEQ_SYNC_EN
  logic [W-1:0] r_shadow_q, g_shadow_q, b_shadow_q;

  // Shadows track the period boundary, not enable, so a frozen sequence still publishes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_shadow_q <= W'(PWM_INTERVAL);
      g_shadow_q <= '0;
      b_shadow_q <= '0;
    end else if (period_start) begin
      r_shadow_q <= W'(dec_r);
      g_shadow_q <= W'(dec_g);
      b_shadow_q <= W'(dec_b);
    end
  end

  assign r_duty = r_shadow_q;
  assign g_duty = g_shadow_q;
  assign b_duty = b_shadow_q;
`else
  assign r_duty = W'(dec_r);
  assign g_duty = W'(dec_g);
  assign b_duty = W'(dec_b);
`endif

  assign phase       = phase_q;
  assign phase_start = phase_start_q;

endmodule

// File: tb/tb_hue_sequencer.sv
// Randomized self-checking bench for hue_sequencer against a time-based hue-wheel model.
// Works with or without HUE_SEQ_SYNC_EN defined.
module tb_hue_sequencer;
  localparam int P   = 12;
  localparam int S   = 4;
  localparam int C   = 3;
  localparam int SS  = P / S;
  localparam int PPH = S * C;    // clocks per phase
  localparam int CYC = 6 * PPH;  // clocks per full hue cycle
  localparam int W   = $clog2(P);

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         enable = 1'b0;
`ifdef HUE_SEQ_SYNC_EN
  logic         period_start = 1'b0;
`endif
  logic [W-1:0] r_duty, g_duty, b_duty;
  logic [2:0]   phase;
  logic         phase_start;

  always #5 clk = ~clk;

  hue_sequencer #(.PWM_INTERVAL(P), .STEPS_PER_PHASE(S), .STEP_CYCLES(C)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
`ifdef HUE_SEQ_SYNC_EN
    .period_start(period_start),
`endif
    .r_duty      (r_duty),
    .g_duty      (g_duty),
    .b_duty      (b_duty),
    .phase       (phase),
    .phase_start (phase_start)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Model state: enabled clocks since reset (mod one hue cycle) plus expected pulse.
  int t = 0;
  int exp_ps = 0;
  int sh_r = P, sh_g = 0, sh_b = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic void decode(input int tt, output int r, output int g, output int b);
    int ph, up, dn;
    ph = (tt / PPH) % 6;
    up = ((tt % PPH) / C) * SS;
    dn = P - up;
    case (ph)
      0: begin r = P;  g = up; b = 0;  end
      1: begin r = dn; g = P;  b = 0;  end
      2: begin r = 0;  g = P;  b = up; end
      3: begin r = 0;  g = dn; b = P;  end
      4: begin r = up; g = 0;  b = P;  end
      default: begin r = P; g = 0; b = dn; end
    endcase
  endfunction

  task automatic model_reset();
    t = 0;
    exp_ps = 0;
    decode(0, sh_r, sh_g, sh_b);
  endtask

  task automatic check_all(input string tag);
    int r, g, b;
    decode(t, r, g, b);
`ifdef HUE_SEQ_SYNC_EN
    r = sh_r; g = sh_g; b = sh_b;
`endif
    check({tag, ".phase"}, 32'(phase), (t / PPH) % 6);
    check({tag, ".pstart"}, 32'(phase_start), exp_ps);
    check({tag, ".r"}, 32'(r_duty), r);
    check({tag, ".g"}, 32'(g_duty), g);
    check({tag, ".b"}, 32'(b_duty), b);
  endtask

  // One clock: model advances on the edge from the inputs held before it, then sample at +1.
  task automatic tick();
    @(posedge clk);
`ifdef HUE_SEQ_SYNC_EN
    if (period_start) decode(t, sh_r, sh_g, sh_b);
`endif
    exp_ps = 0;
    if (enable) begin
      t = (t + 1) % CYC;
      if (t % PPH == 0) exp_ps = 1;
    end
    #1;
  endtask

  // Reset asserted between edges; outputs must settle with no clock edge.
  task automatic async_reset(input string tag);
    #2 rst_n = 1'b0;
    model_reset();
    #1;
    check({tag, ".rst_r"}, 32'(r_duty), P);
    check({tag, ".rst_g"}, 32'(g_duty), 0);
    check({tag, ".rst_b"}, 32'(b_duty), 0);
    check_all(tag);
    @(negedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int pulses;
    int guard;
    model_reset();
    #12;
    check("reset.r", 32'(r_duty), P);
    check("reset.g", 32'(g_duty), 0);
    check("reset.b", 32'(b_duty), 0);
    check_all("reset");

    @(negedge clk);
    rst_n  = 1'b1;
    enable = 1'b1;
`ifdef HUE_SEQ_SYNC_EN
    period_start = 1'b1;
`endif

    // One full hue cycle from reset.
    pulses = 0;
    for (int i = 1; i <= CYC; i++) begin
      tick();
      check_all("cycle");
      if (phase_start) pulses++;
`ifndef HUE_SEQ_SYNC_EN
      if (i == 3)  check("first_step.g", 32'(g_duty), 3);
      if (i == 9)  check("ramp.g", 32'(g_duty), 9);
      if (i == 12) check("phase1.rg", {16'(r_duty), 16'(g_duty)}, {16'd12, 16'd12});
      if (i == 15) check("phase1_dn.r", 32'(r_duty), 9);
`endif
    end
    $display("txn full_cycle t=%0d phase=%0d pulses=%0d", t, phase, pulses);
    check("cycle.pulses", pulses, 6);

    // Freeze in phase 2 at inc=1.
    repeat (27) tick();
    check_all("pre_freeze");
    enable = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      check_all("frozen");
    end
    enable = 1'b1;
    repeat (3) tick();
    check_all("resume");
`ifndef HUE_SEQ_SYNC_EN
    check("resume.b", 32'(b_duty), 6);
`endif
    $display("txn freeze_resume t=%0d b=%0d", t, b_duty);

    // Async reset in the middle of phase 3.
    guard = 0;
    while (t != 40 && guard < 200) begin
      tick();
      check_all("to_ph3");
      guard++;
    end
    check("to_ph3.bound", t, 40);
    async_reset("ph3_rst");
    tick();
    check_all("post_rst");
    $display("txn async_reset t=%0d phase=%0d", t, phase);

`ifdef HUE_SEQ_SYNC_EN
    async_reset("sync_rst");
    period_start = 1'b0;
    enable = 1'b1;
    repeat (30) tick();
    check("sync_hold.rgb", {8'(r_duty), 8'(g_duty), 8'(b_duty)}, {8'd12, 8'd0, 8'd0});
    check("sync_hold.phase", 32'(phase), 2);
    period_start = 1'b1;
    tick();
    period_start = 1'b0;
    check("sync_load.rgb", {8'(r_duty), 8'(g_duty), 8'(b_duty)}, {8'd0, 8'd12, 8'd6});
    check_all("sync_load");
    $display("txn sync_load r=%0d g=%0d b=%0d", r_duty, g_duty, b_duty);
`endif

    // Randomized run.
    for (int i = 0; i < 600; i++) begin
      enable = ($urandom_range(0, 3) != 0);
`ifdef HUE_SEQ_SYNC_EN
      period_start = ($urandom_range(0, 4) == 0);
`endif
      if ($urandom_range(0, 149) == 0) async_reset("rnd_rst");
      tick();
      check_all("rnd");
      $display("txn rnd %0d en=%0d t=%0d ph=%0d ps=%0d rgb=%0d/%0d/%0d",
               i, enable, t, phase, phase_start, r_duty, g_duty, b_duty);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/hue_sequencer.md
HUE_SEQUENCER -- requirements
Module: hue_sequencer

Interface
REQ-001 SHALL have parameter PWM_INTERVAL, default 1200, meaning the PWM period in clocks and the full-on duty value; it SHALL NOT be a power of two (elaboration error).
REQ-002 SHALL have parameter STEPS_PER_PHASE, default 100, meaning the ramp increments per hue phase; it SHALL divide PWM_INTERVAL exactly (elaboration error otherwise).
REQ-003 SHALL have parameter STEP_CYCLES, default 20000, meaning clocks per ramp increment; it SHALL be >= 1.
REQ-004 SHALL have port clk, input, 1 bit: system clock, all state on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: reset, asynchronous assert, active-low.
REQ-006 SHALL have port enable, input, 1 bit: advance the sequence when 1, freeze all state when 0.
REQ-007 SHALL have ports r_duty, g_duty and b_duty, each output, $clog2(PWM_INTERVAL) bits: per-channel duty cycle for downstream pwm instances.
REQ-008 SHALL have port phase, output, 3 bits: current hue phase, 0..5.
REQ-009 SHALL have port phase_start, output, 1 bit: one-cycle pulse on entry to a new phase.
REQ-010 SHALL have port period_start, input, 1 bit: PWM period boundary strobe; present only under HUE_SEQ_SYNC_EN.

Function
REQ-011 SHALL derive STEP_SIZE = PWM_INTERVAL/STEPS_PER_PHASE; the ramp value is inc*STEP_SIZE.
- inc: increment counter, 0..STEPS_PER_PHASE-1.
- UP = ramp value; DN = PWM_INTERVAL - ramp value; MAX = PWM_INTERVAL; 0 = off.
REQ-012 SHALL keep a cycle counter cyc, 0..STEP_CYCLES-1.
- Only while enable=1: cyc increments each clock.
- At STEP_CYCLES-1: cyc wraps to 0 and inc increments.
- When inc wraps from STEPS_PER_PHASE-1 to 0: phase advances by one, with 5 wrapping to 0.
REQ-013 SHALL decode duties per phase as (R,G,B):
- phase 0: (MAX, UP, 0)
- phase 1: (DN, MAX, 0)
- phase 2: (0, MAX, UP)
- phase 3: (0, DN, MAX)
- phase 4: (UP, 0, MAX)
- phase 5: (MAX, 0, DN)
REQ-014 SHALL decode duties combinationally from registered phase and inc, with zero added latency.
REQ-015 SHALL assert phase_start, registered, for exactly the first clock in which the new phase value is visible, including on the 5->0 wrap; it SHALL NOT assert out of reset.
REQ-016 SHALL, when enable=0, hold cyc, inc, phase and duties, and drive phase_start 0; when enable returns to 1, counting resumes from the held cyc.
REQ-017 SHALL keep every duty output within 0..PWM_INTERVAL; no intermediate may wrap, and the width of inc*STEP_SIZE SHALL be sized to avoid overflow.

Reset
REQ-018 SHALL, on rst_n=0, immediately and asynchronously set the following, regardless of the clock:
- cyc=0, inc=0, phase=0, phase_start=0;
- r_duty=PWM_INTERVAL, g_duty=0, b_duty=0;
- under HUE_SEQ_SYNC_EN, shadow registers to these same duty values.
REQ-019 SHALL apply reset mid-phase with no partial update; the first enabled edge after release increments cyc from 0.

Configuration
REQ-020 SHALL use macro HUE_SEQ_SYNC_EN.
- Defined: port period_start exists; r/g/b_duty are driven from shadow registers that load the decoded values on a clock edge where period_start=1, independent of enable, and otherwise hold.
- Undefined: no period_start port; duties are driven directly from the decode per REQ-014.
- Either way: phase and phase_start are unaffected by the macro.

Verification (PWM_INTERVAL=12, STEPS_PER_PHASE=4, STEP_CYCLES=3, so STEP_SIZE=3, 12 clocks per phase, 72 per cycle)
REQ-021 Reset release, then enable=1 -> r=12,g=0,b=0,phase=0; after 3 clocks g=3; after 9 clocks g=9.
REQ-022 Run 12 clocks -> phase=1, r=12, g=12, b=0, phase_start=1 for one clock only; after 3 more clocks r=9.
REQ-023 Run 72 clocks from reset -> phase=0, r=12,g=0,b=0, phase_start pulses once at 5->0; 6 pulses per 72 clocks.
REQ-024 Phase 2 with inc=1 (b=3), enable=0 for 10 clocks -> all outputs frozen, no phase_start; after re-enable, b=6 arrives after the remaining cyc count.
REQ-025 Phase 3 mid-ramp, rst_n pulled low between edges -> outputs go to 12/0/0, phase=0 without a clock edge.
REQ-026 HUE_SEQ_SYNC_EN defined, period_start=0 for 30 clocks -> duties hold 12/0/0 while phase advances to 2; one period_start pulse -> next edge duties = 0/12/6.
